// File: rtl/pong_game_core.sv
// Pong game core: paddle, ball and serve/miss state updated once per frame,
// plus a registered 1-bit-per-channel pixel renderer driven by the beam position.
module pong_game_core #(
   parameter int BALL_SIZE    = 16,
   parameter int PADDLE_W     = 64,
   parameter int PADDLE_H     = 8,
   parameter int PADDLE_Y     = 464,
   parameter int PADDLE_STEP  = 4,
   parameter int BALL_SPEED   = 2,
   parameter int SERVE_FRAMES = 60
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] counter_x,
   input  logic [8:0] counter_y,
   input  logic       in_display_area,
   input  logic       btn_left,
   input  logic       btn_right,
   output logic       vga_r,
   output logic       vga_g,
   output logic       vga_b,
   output logic       miss_pulse,
   output logic [7:0] hit_count
);

   // All geometry is compared at 11 bits so that sums such as x+size never wrap.
   localparam logic [10:0] SCREEN_W  = 11'd640;
   localparam logic [10:0] BALL_SZ   = 11'(BALL_SIZE);
   localparam logic [10:0] PAD_W     = 11'(PADDLE_W);
   localparam logic [10:0] PAD_H     = 11'(PADDLE_H);
   localparam logic [10:0] PAD_Y     = 11'(PADDLE_Y);
   localparam logic [10:0] PAD_STEP  = 11'(PADDLE_STEP);
   localparam logic [10:0] SPEED     = 11'(BALL_SPEED);
   localparam logic [9:0]  CENTER_X  = 10'((640 - BALL_SIZE) / 2);
   localparam logic [8:0]  CENTER_Y  = 9'((480 - BALL_SIZE) / 2);
   localparam logic [9:0]  PAD_START = 10'((640 - PADDLE_W) / 2);
   localparam int          TIMER_W   = (SERVE_FRAMES > 2) ? $clog2(SERVE_FRAMES) : 1;
   localparam logic [TIMER_W-1:0] SERVE_LAST = TIMER_W'(SERVE_FRAMES - 1);

   typedef enum logic {
      SERVE = 1'b0,
      PLAY  = 1'b1
   } state_t;

   state_t             stateReg, stateNext;
   logic [TIMER_W-1:0] serveTimerReg, serveTimerNext;
   logic [9:0]         ballXReg, ballXNext;
   logic [8:0]         ballYReg, ballYNext;
   logic               dirXReg, dirXNext;      // 1 = right, 0 = left
   logic               dirYReg, dirYNext;      // 1 = down,  0 = up
   logic [9:0]         paddleXReg, paddleXNext;
   logic [7:0]         hitCountReg, hitCountNext;
   logic               missReg, missNext;

   logic        frameTick;
   logic [10:0] ballX11, ballY11, paddleX11;
   logic [10:0] beamX11, beamY11;
   logic        overlap;
   logic        ballPx, paddlePx;

   // The single cycle per frame where the beam sits at the start of vertical blanking.
   assign frameTick = (counter_x == 10'd0) && (counter_y == 9'd480);

   assign ballX11   = {1'b0, ballXReg};
   assign ballY11   = {2'b0, ballYReg};
   assign paddleX11 = {1'b0, paddleXReg};
   assign beamX11   = {1'b0, counter_x};
   assign beamY11   = {2'b0, counter_y};

   // Horizontal overlap of ball and paddle using the pre-update positions.
   assign overlap = (ballX11 + BALL_SZ > paddleX11) && (ballX11 < paddleX11 + PAD_W);

   // Game state register: everything moves together on the frame tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateReg      <= SERVE;
         serveTimerReg <= '0;
         ballXReg      <= CENTER_X;
         ballYReg      <= CENTER_Y;
         dirXReg       <= 1'b1;
         dirYReg       <= 1'b1;
         paddleXReg    <= PAD_START;
         hitCountReg   <= 8'd0;
         missReg       <= 1'b0;
      end else begin
         stateReg      <= stateNext;
         serveTimerReg <= serveTimerNext;
         ballXReg      <= ballXNext;
         ballYReg      <= ballYNext;
         dirXReg       <= dirXNext;
         dirYReg       <= dirYNext;
         paddleXReg    <= paddleXNext;
         hitCountReg   <= hitCountNext;
         missReg       <= missNext;
      end
   end

   // Next-state logic: paddle motion, serve countdown, ball motion with bounces and miss.
   always_comb begin
      stateNext      = stateReg;
      serveTimerNext = serveTimerReg;
      ballXNext      = ballXReg;
      ballYNext      = ballYReg;
      dirXNext       = dirXReg;
      dirYNext       = dirYReg;
      paddleXNext    = paddleXReg;
      hitCountNext   = hitCountReg;
      missNext       = 1'b0;

      if (frameTick) begin
         // Paddle responds in both states; opposing buttons cancel.
         if (btn_left && !btn_right) begin
            if (paddleX11 < PAD_STEP) paddleXNext = 10'd0;
            else                      paddleXNext = 10'(paddleX11 - PAD_STEP);
         end else if (btn_right && !btn_left) begin
            if (paddleX11 + PAD_STEP > SCREEN_W - PAD_W) paddleXNext = 10'(SCREEN_W - PAD_W);
            else                                         paddleXNext = 10'(paddleX11 + PAD_STEP);
         end

         case (stateReg)
            SERVE: begin
               ballXNext = CENTER_X;
               ballYNext = CENTER_Y;
               if (serveTimerReg == SERVE_LAST) begin
                  serveTimerNext = '0;
                  stateNext      = PLAY;
                  dirYNext       = 1'b1;
               end else begin
                  serveTimerNext = serveTimerReg + 1'b1;
               end
            end

            PLAY: begin
               // Horizontal motion with wall bounce (ball clamped flush to the wall).
               if (dirXReg) begin
                  if (ballX11 + BALL_SZ + SPEED > SCREEN_W) begin
                     ballXNext = 10'(SCREEN_W - BALL_SZ);
                     dirXNext  = 1'b0;
                  end else begin
                     ballXNext = 10'(ballX11 + SPEED);
                  end
               end else begin
                  if (ballX11 < SPEED) begin
                     ballXNext = 10'd0;
                     dirXNext  = 1'b1;
                  end else begin
                     ballXNext = 10'(ballX11 - SPEED);
                  end
               end

               // Vertical motion: ceiling bounce, paddle hit or miss at the paddle row.
               if (!dirYReg) begin
                  if (ballY11 < SPEED) begin
                     ballYNext = 9'd0;
                     dirYNext  = 1'b1;
                  end else begin
                     ballYNext = 9'(ballY11 - SPEED);
                  end
               end else if (ballY11 + BALL_SZ + SPEED >= PAD_Y) begin
                  if (overlap) begin
                     ballYNext    = 9'(PAD_Y - BALL_SZ);
                     dirYNext     = 1'b0;
                     hitCountNext = hitCountReg + 8'd1;
                  end else begin
                     // A miss overrides whatever the x axis computed this tick.
                     missNext  = 1'b1;
                     stateNext = SERVE;
                     ballXNext = CENTER_X;
                     ballYNext = CENTER_Y;
                  end
               end else begin
                  ballYNext = 9'(ballY11 + SPEED);
               end
            end

            default: stateNext = SERVE;
         endcase
      end
   end

   assign ballPx   = (beamX11 >= ballX11)   && (beamX11 < ballX11 + BALL_SZ) &&
                     (beamY11 >= ballY11)   && (beamY11 < ballY11 + BALL_SZ);
   assign paddlePx = (beamX11 >= paddleX11) && (beamX11 < paddleX11 + PAD_W) &&
                     (beamY11 >= PAD_Y)     && (beamY11 < PAD_Y + PAD_H);

   // Pixel colour register: ball (white) beats paddle (green); blank outside the visible area.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {vga_r, vga_g, vga_b} <= 3'b000;
      end else if (!in_display_area) begin
         {vga_r, vga_g, vga_b} <= 3'b000;
      end else if (ballPx) begin
         {vga_r, vga_g, vga_b} <= 3'b111;
      end else if (paddlePx) begin
         {vga_r, vga_g, vga_b} <= 3'b010;
      end else begin
         {vga_r, vga_g, vga_b} <= 3'b000;
      end
   end

   assign miss_pulse = missReg;
   assign hit_count  = hitCountReg;

endmodule
